// File: rtl/interrupt_request_priority.sv
// 8259 IRR/ISR datapath: request capture, rotating priority resolution,
// in-service tracking and INT generation in fully nested mode.
module interrupt_request_priority #(
    parameter int NUM_IRQ = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ir,
    input  logic       clear_state,
    input  logic       level_edge_triggered,
    input  logic [7:0] int_mask,
    input  logic [7:0] eoi,
    input  logic       latch_in_service,
    input  logic       freeze,
    input  logic [2:0] priority_rotate,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] acknowledged_level,
    output logic       int_request
);

    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] ir_prev_q, ir_prev_d;
    logic [2:0] ack_q, ack_d;
    logic       int_q, int_d;

    logic [2:0] shift;
    logic [7:0] req_rot, isr_rot;
    logic [7:0] req_first, isr_first;
    logic [2:0] req_rank, isr_rank;
    logic [7:0] req_winner, isr_winner;
    logic [7:0] latch_vec;

    function automatic logic [7:0] rot_r(input logic [7:0] v,
                                         input logic [2:0] s);
        logic [15:0] w;
        w = {v, v} >> s;
        return w[7:0];
    endfunction

    function automatic logic [7:0] rot_l(input logic [7:0] v,
                                         input logic [2:0] s);
        logic [15:0] w;
        w = {v, v} << s;
        return w[15:8];
    endfunction

    function automatic logic [2:0] first_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Resolve in rotated space so a fixed LSB-first search sees the
    // highest-priority level at bit 0; rank is the rotated bit index.
    always_comb begin
        shift      = priority_rotate + 3'd1;
        req_rot    = rot_r(irr_q & ~int_mask, shift);
        isr_rot    = rot_r(isr_q, shift);
        req_first  = req_rot & (~req_rot + 8'd1);
        isr_first  = isr_rot & (~isr_rot + 8'd1);
        req_rank   = first_idx(req_rot);
        isr_rank   = first_idx(isr_rot);
        req_winner = rot_l(req_first, shift);
        isr_winner = rot_l(isr_first, shift);
        latch_vec  = latch_in_service ? req_winner : 8'h00;
    end

    always_comb begin
        irr_d     = irr_q & ~latch_vec;
        ir_prev_d = ir_prev_q;
        isr_d     = (isr_q & ~eoi) | latch_vec;
        ack_d     = ack_q;
        int_d     = (|req_rot) && (~|isr_q || (req_rank < isr_rank));

        if (!freeze) begin
            ir_prev_d = ir;
            if (level_edge_triggered) begin
                irr_d = ir & ~latch_vec;
            end else begin
                irr_d = (irr_q | (ir & ~ir_prev_q)) & ir & ~latch_vec;
            end
        end

        if (latch_in_service) begin
            ack_d = (|req_winner) ? encode(req_winner) : 3'd7;
        end

        if (clear_state) begin
            irr_d     = 8'h00;
            isr_d     = 8'h00;
            ack_d     = 3'd0;
            int_d     = 1'b0;
            ir_prev_d = ir;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irr_q     <= 8'h00;
            isr_q     <= 8'h00;
            ack_q     <= 3'd0;
            int_q     <= 1'b0;
            ir_prev_q <= 8'hFF;
        end else begin
            irr_q     <= irr_d;
            isr_q     <= isr_d;
            ack_q     <= ack_d;
            int_q     <= int_d;
            ir_prev_q <= ir_prev_d;
        end
    end

    assign irr                      = irr_q;
    assign isr                      = isr_q;
    assign highest_level_in_service = isr_winner;
    assign acknowledged_level       = ack_q;
    assign int_request              = int_q;

endmodule

// File: doc/interrupt_request_priority.md
Name: interrupt_request_priority

Overview:
Datapath stage directly downstream of the 8259 control block. It registers the eight IR lines into the IRR (edge or level mode) and applies the mask. A rotating priority resolver chooses the next request and holds the ISR. The stage drives INT to the control block and returns highest_level_in_service for specific/non-specific EOI handling.

Parameters:
NUM_IRQ, 8, number of interrupt lines; the design is fixed at 8 and the value exists for documentation only.

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
ir  input  8  external interrupt request lines IR7..IR0
clear_state  input  1  ICW1 write strobe; re-initialises IRR, ISR and edge history
level_edge_triggered  input  1  1 = level mode, 0 = edge mode (LTIM)
int_mask  input  8  IMR from control block; 1 = masked
eoi  input  8  one-hot ISR clear vector from control block
latch_in_service  input  1  acknowledge strobe; commits current winner into ISR
freeze  input  1  high during INTA sequence; holds IRR sampling
priority_rotate  input  3  lowest-priority level; default 3'b111 makes IR0 highest
irr  output  8  interrupt request register
isr  output  8  in-service register
highest_level_in_service  output  8  one-hot highest-priority ISR bit, 0 if ISR empty
acknowledged_level  output  3  binary level committed by last latch_in_service
int_request  output  1  INT request to control block

Behaviour:
- All state changes on the rising edge of clk. reset_n=0 at an edge: irr=0, isr=0, int_request=0, acknowledged_level=0, ir_prev=8'hFF. Reset wins over every other input.
- clear_state (when reset_n=1): same clears as reset, except ir_prev is loaded with the current ir. Priority over latch_in_service and eoi.
- Edge history: ir_prev<=ir every cycle that freeze=0.
- IRR, freeze=0:
  - edge mode: bit set on ir & ~ir_prev; cleared when ir is low; cleared when its bit is latched.
  - level mode: irr<=ir; the latched bit is cleared for the latch cycle only.
- IRR, freeze=1: IRR holds. The clear on a latched bit is still applied.
- Priority order: the highest level is (priority_rotate+1) mod 8, descending cyclically to priority_rotate. Implemented by rotating the vector right by (priority_rotate+1), doing a fixed LSB-first find-first, then rotating back.
- req_winner = one-hot highest of (irr & ~int_mask). isr_winner = one-hot highest of isr, and drives highest_level_in_service combinationally.
- int_request is registered with 1-cycle latency. It is 1 when req_winner is nonzero and ranks strictly higher than isr_winner, or isr is empty. Otherwise 0.
- A request at the same level as, or lower than, the in-service level never asserts INT (fully nested mode).
- ISR next value = (isr & ~eoi) | (latch_in_service ? req_winner : 0). If eoi and latch hit the same bit in one cycle, the bit ends set.
- On latch_in_service with a nonzero req_winner, acknowledged_level <= encode(req_winner). With a zero req_winner (spurious acknowledge), ISR is unchanged and acknowledged_level <= 3'd7, per 8259 spurious IR7.
- Masking: int_mask affects only request selection and INT. Masked IRR bits still latch and remain visible on irr. ISR bits are never masked.
- Rotation changes take effect on the same cycle's combinational winners, with no pipeline bubble.
- eoi bits for non-set ISR bits have no effect. Multiple eoi bits clear all of them.

Test Plan:
- Reset/init: reset_n=0 with ir=8'hFF, then release -> irr=0, isr=0, int_request=0. No edge is detected until a line falls and rises again.
- Edge priority: edge mode, mask=0, rotate=7, ir=8'b0001_0100 rising together -> irr=8'h14; int_request=1 on the next cycle. latch_in_service -> isr=8'h04, acknowledged_level=2, irr=8'h10.
- Nesting/EOI: with isr=8'h04, raise IR1 -> int_request=1; raise IR5 only -> int_request=0. Then eoi=8'h04 -> isr=0, and int_request=1 for IR5 one cycle later.
- Rotation: rotate=3'd2, irr=8'h09 -> IR3 wins, and latch gives isr=8'h08. The same request with rotate=7 gives isr=8'h01.
- Level/mask/freeze: level mode, int_mask=8'h01, ir=8'h01 -> irr=8'h01, int_request=0. Set freeze=1 and drop ir -> irr holds 8'h01 until freeze=0.
- Spurious and collision: irr=0 with latch_in_service pulse -> isr unchanged, acknowledged_level=7. eoi=8'h02 together with a latch of IR1 -> isr bit1=1.
